// File: rtl/data_mem_responder.sv
// Memory responder: byte/half/word loads and stores on a word RAM; `MISALIGN_TRAP_EN enables misalignment trapping.
// Latency: memReady pulses WAIT_CYCLES+2 cycles after the request is sampled in IDLE.
// Backpressure: requests are only sampled in IDLE; busy stays high until the DONE cycle ends.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        memReady,
  output logic        busy,
  output logic        err
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 start;
  logic                 op_rd;
  logic [2:0]           op_f3;
  logic [ADDR_WIDTH+1:0] op_addr;
  logic [31:0]          op_wdata;
  logic [31:0]          mem [2**ADDR_WIDTH];

  logic                 is_b, is_h, trap;
  logic [3:0]           wr_be;
  logic [31:0]          wr_dat, ram_word, ld_val;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic                 unused_addr;

  assign unused_addr = ^addr[31:ADDR_WIDTH+2];

  always_ff @(posedge CLK) begin
    if (RES) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (memRead || memWrite) begin
          start = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nxt = ACCESS;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_nxt = ACCESS;
        else           cnt_nxt   = cnt - 1'b1;
      end
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured once; anything on the inputs while busy is ignored.
  always_ff @(posedge CLK) begin
    if (RES) begin
      op_rd    <= 1'b0;
      op_f3    <= '0;
      op_addr  <= '0;
      op_wdata <= '0;
    end else if (start) begin
      op_rd    <= memRead;
      op_f3    <= funct3;
      op_addr  <= addr[ADDR_WIDTH+1:0];
      op_wdata <= wdata;
    end
  end

  // Funct3 low bits pick the size; 011/110/111 fall through to word.
  assign is_b = (op_f3[1:0] == 2'b00);
  assign is_h = (op_f3[1:0] == 2'b01);

`ifdef MISALIGN_TRAP_EN
  assign trap = (is_h && op_addr[0]) || (!is_b && !is_h && (op_addr[1:0] != 2'b00));
  assign err  = (state == DONE) && trap;
`else
  assign trap = 1'b0;
  assign err  = 1'b0;
`endif

  always_comb begin
    wr_be  = 4'b1111;
    wr_dat = op_wdata;
    if (is_b) begin
      wr_be  = 4'b0001 << op_addr[1:0];
      wr_dat = {4{op_wdata[7:0]}};
    end else if (is_h) begin
      wr_be  = op_addr[1] ? 4'b1100 : 4'b0011;
      wr_dat = {2{op_wdata[15:0]}};
    end
  end

  assign ram_word = mem[op_addr[ADDR_WIDTH+1:2]];
  assign ld_byte  = ram_word[8*op_addr[1:0] +: 8];
  assign ld_half  = op_addr[1] ? ram_word[31:16] : ram_word[15:0];

  always_comb begin
    ld_val = ram_word;
    case (op_f3)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_val = {24'h0, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_val = {16'h0, ld_half};
      default: ld_val = ram_word;
    endcase
  end

  // RAM is not reset; a reset landing on ACCESS must still block the write.
  always_ff @(posedge CLK) begin
    if (!RES && state == ACCESS && !op_rd && !trap) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[op_addr[ADDR_WIDTH+1:2]][8*i +: 8] <= wr_dat[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RES)                             rdata <= '0;
    else if (state == ACCESS && op_rd)   rdata <= trap ? 32'h0 : ld_val;
  end

  assign memReady = (state == DONE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one instance with WAIT_CYCLES=2, one with WAIT_CYCLES=0.
module tb_data_mem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          bsy;
  } exp_t;

  logic        CLK = 1'b0;
  logic [1:0]  res, mem_read, mem_write, mem_ready, busy, err;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata [2];
  logic [31:0] last_rd [2];
  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always #5 CLK = ~CLK;

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) u_dut0 (
    .CLK(CLK), .RES(res[0]), .memRead(mem_read[0]), .memWrite(mem_write[0]),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata[0]),
    .memReady(mem_ready[0]), .busy(busy[0]), .err(err[0])
  );

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut1 (
    .CLK(CLK), .RES(res[1]), .memRead(mem_read[1]), .memWrite(mem_write[1]),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata[1]),
    .memReady(mem_ready[1]), .busy(busy[1]), .err(err[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One request; expectation queued at drive time, checked when memReady appears.
  task automatic access(input int d, input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit exp_err, input string tag);
    exp_t e;
    int   n;
    int   bcnt;
    e.rdata = rd ? exp_rd : last_rd[d];
    e.err   = exp_err;
    e.lat   = (d == 0) ? 4 : 2;
    e.bsy   = (d == 0) ? 3 : 1;
    sb.push_back(e);
    @(negedge CLK);
    funct3 = f3; addr = a; wdata = wd;
    mem_read[d] = rd; mem_write[d] = wr;
    @(posedge CLK); #1;
    mem_read[d] = 1'b0; mem_write[d] = 1'b0;
    n = 1; bcnt = 0;
    while (!mem_ready[d] && n < 40) begin
      bcnt += int'(busy[d]);
      @(posedge CLK); #1;
      n++;
    end
    e = sb.pop_front();
    if (!mem_ready[d]) begin
      chk({tag, "_timeout"}, 32'(n), 32'(e.lat));
    end else begin
      chk({tag, "_lat"}, 32'(n), 32'(e.lat));
      chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(e.bsy));
      chk({tag, "_rdata"}, rdata[d], e.rdata);
      chk({tag, "_err"}, 32'(err[d]), 32'(e.err));
      last_rd[d] = e.rdata;
      @(posedge CLK); #1;
      chk({tag, "_one_pulse"}, 32'(mem_ready[d]), 32'd0);
      chk({tag, "_idle"}, 32'(busy[d]), 32'd0);
    end
  endtask

  initial begin
    int pulses;
    res = 2'b11; mem_read = 2'b00; mem_write = 2'b00;
    funct3 = 3'b010; addr = '0; wdata = '0;
    repeat (2) @(posedge CLK);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst%0d_rdata", d), rdata[d], 32'h0);
      chk($sformatf("rst%0d_ready", d), 32'(mem_ready[d]), 32'd0);
      chk($sformatf("rst%0d_busy", d), 32'(busy[d]), 32'd0);
      chk($sformatf("rst%0d_err", d), 32'(err[d]), 32'd0);
      last_rd[d] = 32'h0;
    end
    res = 2'b00;

    access(0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw10");
    access(0, 1, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw10");
    access(0, 0, 1, 3'b000, 32'h13, 32'hAAAAAA80, 32'h0, 1'b0, "sb13");
    access(0, 1, 0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, "lw10_sb");
    access(0, 1, 0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, "lb13");
    access(0, 1, 0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0, "lbu13");
    access(0, 0, 1, 3'b001, 32'h12, 32'h55551234, 32'h0, 1'b0, "sh12");
    access(0, 1, 0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0, "lw10_sh");
    access(0, 1, 0, 3'b001, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, "lh10");
    access(0, 1, 0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, "lhu10");
    access(0, 1, 1, 3'b010, 32'h10, 32'hFFFFFFFF, 32'h1234BEEF, 1'b0, "both");
    access(0, 1, 0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0, "lw10_both");
    access(0, 1, 0, 3'b010, 32'h1010, 32'h0, 32'h1234BEEF, 1'b0, "lw_wrap");
    access(0, 1, 0, 3'b011, 32'h10, 32'h0, 32'h1234BEEF, 1'b0, "ld_f3_011");

    // Reset during the first WAIT cycle of a store: aborted, no write, no pulse.
    access(0, 0, 1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, "sw20");
    @(negedge CLK);
    funct3 = 3'b010; addr = 32'h20; wdata = 32'h55; mem_write[0] = 1'b1;
    @(posedge CLK); #1;
    mem_write[0] = 1'b0;
    chk("abort_busy_before", 32'(busy[0]), 32'd1);
    @(negedge CLK);
    res[0] = 1'b1;
    @(posedge CLK); #1;
    res[0] = 1'b0;
    chk("abort_busy_after", 32'(busy[0]), 32'd0);
    chk("abort_rdata_cleared", rdata[0], 32'h0);
    last_rd[0] = 32'h0;
    pulses = 0;
    repeat (6) begin
      @(posedge CLK); #1;
      pulses += int'(mem_ready[0]);
    end
    chk("abort_no_ready", 32'(pulses), 32'd0);
    access(0, 1, 0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, "lw20_after_abort");

    // Misaligned accesses.
    access(0, 1, 0, 3'b010, 32'h11, 32'h0, TRAP ? 32'h0 : 32'h1234BEEF, TRAP, "lw11_mis");
    access(0, 0, 1, 3'b010, 32'h11, 32'h0, 32'h0, TRAP, "sw11_mis");
    access(0, 1, 0, 3'b010, 32'h10, 32'h0, TRAP ? 32'h1234BEEF : 32'h0, 1'b0, "lw10_after_mis");

    // Zero wait states.
    access(1, 0, 1, 3'b010, 32'h40, 32'h11223344, 32'h0, 1'b0, "w0_sw40");
    access(1, 1, 0, 3'b010, 32'h40, 32'h0, 32'h11223344, 1'b0, "w0_lw40");
    access(1, 1, 0, 3'b101, 32'h42, 32'h0, 32'h00001122, 1'b0, "w0_lhu42");
    access(1, 0, 1, 3'b000, 32'h40, 32'h000000F0, 32'h0, 1'b0, "w0_sb40");
    access(1, 1, 0, 3'b000, 32'h40, 32'h0, 32'hFFFFFFF0, 1'b0, "w0_lb40");
    access(1, 1, 0, 3'b010, 32'h40, 32'h0, 32'h112233F0, 1'b0, "w0_lw40_sb");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the core's memory-access interface: accepts memRead/memWrite requests from the multicycle control path and performs byte, half or word loads and stores on an internal word-organised RAM.
- Inserts configurable wait states and returns a one-cycle completion pulse, so the control FSM can stall MEM_ACCESS until data is ready.
- Sits between control_unit/datapath and data storage, replacing a zero-latency ideal memory.

Parameters:
- ADDR_WIDTH, 10, word-address bits; RAM depth = 2**ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2, extra wait states before the RAM access; 0 is legal.

Ports:
- CLK  input  1  clock, rising edge.
- RES  input  1  reset; synchronous, active-high.
- memRead  input  1  load request, level, sampled only in IDLE.
- memWrite  input  1  store request, level, sampled only in IDLE.
- funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  input  32  byte address.
- wdata  input  32  store data, right-aligned.
- rdata  output  32  load result, extended to 32 bits; held until the next load completion.
- memReady  output  1  one-cycle completion pulse, for loads and stores.
- busy  output  1  high whenever state != IDLE.
- err  output  1  misalignment flag, pulses with memReady; constant 0 without the optional feature.

Behaviour:
- Reset (synchronous, RES=1 at a rising edge):
  - state=IDLE, rdata=0, memReady=0, busy=0, err=0, wait counter=0.
  - RAM contents are not cleared.
  - RES aborts any transaction in flight. RES in the same cycle as ACCESS suppresses the write.
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - If memRead or memWrite is high, latch addr, funct3, wdata and op.
  - memRead has priority when both are high; the store is dropped.
  - Next state is WAIT with counter=WAIT_CYCLES-1, or ACCESS directly when WAIT_CYCLES=0.
- WAIT: decrement the counter; go to ACCESS when the counter is 0.
- ACCESS: perform the RAM read or the byte-enabled write; go to DONE.
- DONE:
  - memReady=1 for exactly this cycle; rdata is valid from this cycle.
  - Next state is IDLE.
- Latency: request sampled at edge t gives memReady high in cycle t+WAIT_CYCLES+2 (t+2 when WAIT_CYCLES=0).
- Request handling:
  - Request changes while busy are ignored.
  - The requester must deassert by the cycle after memReady; a request still high in IDLE starts a new transaction.
- Addressing:
  - Word index = addr[ADDR_WIDTH+1:2]; upper address bits are ignored, so accesses wrap modulo the RAM size.
  - Byte lane is addr[1:0]. Half lane is addr[1] (bytes 0-1 or 2-3).
- Stores (funct3[2] ignored):
  - SB writes wdata[7:0] to the selected lane.
  - SH writes wdata[15:0] to the selected half.
  - SW writes all 4 bytes.
  - Unselected bytes are unchanged.
- Loads:
  - B/H sign-extend; BU/HU zero-extend; W returns the full word.
- Undefined funct3 (011, 110, 111) is treated as a word access.
- A store never changes rdata.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, still traverses WAIT/ACCESS/DONE with the same latency.
  - The store is suppressed, a load sets rdata=0, and err=1 coincident with memReady.
- Undefined:
  - Low address bits are silently masked: half uses addr[1], word ignores addr[1:0].
  - The access proceeds normally; err is tied 0.

Test Plan:
- WAIT_CYCLES=2: SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 -> memReady high 4 cycles after each request; rdata=0xDEADBEEF.
- SB addr=0x13 wdata=0x80 over 0xDEADBEEF -> LW gives 0x80ADBEEF; LB 0x13 gives 0xFFFFFF80; LBU 0x13 gives 0x00000080.
- SH addr=0x12 wdata=0x1234 -> LW 0x10 gives 0x1234BEEF; LH 0x10 gives 0xFFFFBEEF; LHU 0x10 gives 0x0000BEEF.
- memRead and memWrite both high at addr=0x10 -> load served; word unchanged; exactly one memReady pulse; busy high for 3 cycles.
- RES asserted in the WAIT cycle of SW addr=0x20 wdata=0x55 -> no memReady, busy=0 next cycle, later LW 0x20 returns the prior value; with WAIT_CYCLES=0, memReady comes 2 cycles after the request.
- With MISALIGN_TRAP_EN: LW addr=0x11 -> err=1 and memReady=1 same cycle, rdata=0. Without it: the same access returns the word at 0x10 and err=0.
